// File: rtl/shift_register_n_if.sv
// rtl/shift_register_n_if.sv - control/data bundle for the N-bit universal shift register
//
// Signals:
//   E    clock enable (0 = all state holds)
//   L    parallel load request (priority over M/RTL)
//   M    mode: 00 logical shift, 01 rotate, 10 arithmetic shift, 11 hold
//   RTL  direction: 1 = toward MSB, 0 = toward LSB
//   SI   serial input used by logical shift
//   D    parallel load data
//   Q    register contents
//   nQ   bitwise complement of Q
//   SO   bit that leaves the register on the next shift in the current direction
//   CNT  shifts since last load/reset, saturating at WIDTH
//   DONE CNT == WIDTH
// Modports: master drives the controls and observes the outputs; slave is the register.

interface shift_register_n_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             E;
    logic             L;
    logic [1:0]       M;
    logic             RTL;
    logic             SI;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] nQ;
    logic             SO;
    logic [CW-1:0]    CNT;
    logic             DONE;

    modport master (
        output E, L, M, RTL, SI, D,
        input  Q, nQ, SO, CNT, DONE
    );

    modport slave (
        input  E, L, M, RTL, SI, D,
        output Q, nQ, SO, CNT, DONE
    );
endinterface

// File: rtl/shift_register_n.sv
// rtl/shift_register_n.sv - N-bit universal shift register with load, rotate, arithmetic shift and shift counter
//
// Ports:
//   C     clock, all state updates on the rising edge
//   nRST  asynchronous active-low reset; clears Q and CNT without a clock edge
//   bus   shift_register_n_if.slave: E, L, M, RTL, SI, D in; Q, nQ, SO, CNT, DONE out
//
// Per rising edge: E=0 holds everything; E=1,L=1 loads D and clears CNT;
// E=1,L=0 applies the mode in M in the direction given by RTL. Every effective
// shift (any mode except hold) bumps CNT, which saturates at WIDTH.

module shift_register_n #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                  C,
    input  logic                  nRST,
    shift_register_n_if.slave     bus
);

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ROTATE  = 2'b01,
        MODE_ARITH   = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_shift;
    mode_t            mode;

    assign mode = mode_t'(bus.M);

    // Next value for a shift in the current mode/direction. The hold case is
    // never selected by the register (it is gated below) but keeps the mux total.
    always_comb begin
        q_shift = q;
        unique case (mode)
            MODE_LOGICAL: begin
                if (bus.RTL) q_shift = {q[WIDTH-2:0], bus.SI};
                else         q_shift = {bus.SI, q[WIDTH-1:1]};
            end
            MODE_ROTATE: begin
                if (bus.RTL) q_shift = {q[WIDTH-2:0], q[WIDTH-1]};
                else         q_shift = {q[0], q[WIDTH-1:1]};
            end
            MODE_ARITH: begin
                // Toward MSB fills zero; toward LSB replicates the sign bit.
                if (bus.RTL) q_shift = {q[WIDTH-2:0], 1'b0};
                else         q_shift = {q[WIDTH-1], q[WIDTH-1:1]};
            end
            MODE_HOLD: begin
                q_shift = q;
            end
            default: begin
                q_shift = q;
            end
        endcase
    end

    always_ff @(posedge C or negedge nRST) begin
        if (!nRST) begin
            q   <= '0;
            cnt <= '0;
        end else if (bus.E) begin
            if (bus.L) begin
                q   <= bus.D;
                cnt <= '0;
            end else if (mode != MODE_HOLD) begin
                q <= q_shift;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // All outputs decode registered state; SO follows the live RTL input so it
    // always names the bit about to leave on the next edge.
    assign bus.Q    = q;
    assign bus.nQ   = ~q;
    assign bus.SO   = bus.RTL ? q[WIDTH-1] : q[0];
    assign bus.CNT  = cnt;
    assign bus.DONE = (cnt == CNT_MAX);

endmodule
